md_ctrl: RTL
============

# md_ctrl

Multi-cycle sequencer for the HI/LO multiply/divide unit. It accepts mult/multu/div/divu/mthi/mtlo operations from the execute stage, latches operands, and holds the unit busy for a fixed per-class latency. It then commits the 64-bit result to architectural HI/LO registers that it owns. It raises a combinational stall so later HI/LO reads and new operations wait until the result is committed.

## Interface
Parameters:
- MUL_LAT, 4: cycles from accept to HI/LO commit for mult/multu (≥1)
- DIV_LAT, 16: cycles from accept to HI/LO commit for div/divu (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request, valid with md_op/rs/rt
- md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 treated as none
- rs  in  32  operand A / dividend / mthi-mtlo source
- rt  in  32  operand B / divisor
- hilo_rd  in  1  execute stage wants HI or LO (mfhi/mflo) this cycle
- flush  in  1  pipeline flush; aborts an in-flight op
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  registered; high while a mult/div is in flight
- done  out  1  registered one-cycle pulse after a mult/div commit
- stall  out  1  combinational; busy & (hilo_rd | start)

## Operation
- States: IDLE, BUSY. A 5-bit counter cnt and latched op/operands (op_q, a_q, b_q).
- IDLE, start=1, flush=0:
  - mult/multu/div/divu: latch operands; cnt ← LAT-1; go to BUSY.
  - mthi: hi ← rs. mtlo: lo ← rs. Both commit at the accepting edge, with no BUSY.
  - none: ignored.
- BUSY: cnt decrements each cycle. At the edge where cnt==0, commit HI/LO, go to IDLE, and set done=1 for one cycle.
- start while BUSY is not accepted. stall holds it; the requester re-presents it.
- Arithmetic on latched operands:
  - mult: {hi,lo} ← signed 64-bit a_q*b_q.
  - multu: {hi,lo} ← unsigned product.
  - div: lo ← quotient, truncated toward zero; hi ← remainder with the sign of the dividend. Example: -7/2 → lo=-3, hi=-1.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / -1: lo=0x80000000, hi=0.
- Divide by zero (b_q==0): hi/lo unchanged; done still pulses.
- flush=1: state → IDLE, cnt ← 0, busy ← 0 next edge, no commit, no done. flush in IDLE cancels a same-cycle start, including mthi/mtlo.
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, cnt=0, op_q=none.

## Timing
- Accept edge E0. busy is high in cycles E0+1 … E0+LAT. hi/lo show the new value from E0+LAT. done is high in the cycle after E0+LAT. busy is low in that same cycle.
- Back-to-back: a new start is accepted in the cycle done is high (state IDLE).
- stall is combinational, with no added latency. hilo_rd in the cycle after commit sees the new value without stall.
- mthi/mtlo: result is visible the cycle after accept; busy and done stay 0.
- Reset asserted mid-operation: immediate return to reset values, with no partial commit.

## Configuration
- MD_DIV0_FAST_EN defined: div/divu with rt==0 is not entered into BUSY. It completes at the accept edge, hi/lo are unchanged, and done pulses in the next cycle.
- Not defined: divide by zero takes the full DIV_LAT cycles, then commits nothing and pulses done.

## Test plan
- Reset: assert rst_n=0 mid-BUSY → hi=lo=0, busy=0, done=0 immediately. Release, then idle 3 cycles → no change.
- mult rs=0xFFFFFFFE (-2), rt=3: hi=0xFFFFFFFF and lo=0xFFFFFFFA exactly 4 cycles after accept. busy high for 4 cycles, done pulses once. multu with the same operands → hi=0x2, lo=0xFFFFFFFA.
- div rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 16 cycles. divu rs=7, rt=2 → lo=3, hi=1.
- div rt=0 with hi/lo preloaded by mthi 0x11, mtlo 0x22 → hi/lo stay 0x11/0x22. done arrives 1 cycle after accept with MD_DIV0_FAST_EN, 16 without.
- hilo_rd and a second start during BUSY → stall=1 every busy cycle, second op not accepted. Re-presented op accepted in the done cycle. Its result commits LAT cycles later.
- flush at cycle 5 of a div → busy drops next edge, hi/lo unchanged, no done. A same-cycle start+flush of mtlo 0x55 → lo unchanged.

Source files
------------

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer: accepts one mult/div op, counts out its latency, commits HI/LO.
// Optional MD_DIV0_FAST_EN: divide by zero finishes at the accept edge instead of running DIV_LAT cycles.
module md_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        hilo_rd,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        dbg_state_o
);

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Arithmetic on the latched operands; only sampled at the commit edge.
    logic [63:0] prod_s, prod_u;
    logic [31:0] safe_b, abs_a, abs_b, mag_q, mag_r, quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // safe_b keeps the dividers defined when b_q==0; that result is never committed.
    assign safe_b = (b_q == 32'd0) ? 32'd1 : b_q;
    assign abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b  = safe_b[31] ? (~safe_b + 32'd1) : safe_b;
    assign mag_q  = abs_a / abs_b;
    assign mag_r  = abs_a % abs_b;
    // Sign-magnitude form makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
    assign quo_s  = (a_q[31] ^ b_q[31]) ? (~mag_q + 32'd1) : mag_q;
    assign rem_s  = a_q[31] ? (~mag_r + 32'd1) : mag_r;
    assign quo_u  = a_q / safe_b;
    assign rem_u  = a_q % safe_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                op_d    = md_op;
                                a_d     = rs;
                                b_d     = rt;
                                cnt_d   = 5'(MUL_LAT - 1);
                                state_d = BUSY;
                                busy_d  = 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MD_DIV0_FAST_EN
                                if (rt == 32'd0) begin
                                    done_d = 1'b1;
                                end else begin
                                    op_d    = md_op;
                                    a_d     = rs;
                                    b_d     = rt;
                                    cnt_d   = 5'(DIV_LAT - 1);
                                    state_d = BUSY;
                                    busy_d  = 1'b1;
                                end
`else
                                op_d    = md_op;
                                a_d     = rs;
                                b_d     = rt;
                                cnt_d   = 5'(DIV_LAT - 1);
                                state_d = BUSY;
                                busy_d  = 1'b1;
`endif
                            end
                            OP_MTHI: hi_d = rs;
                            OP_MTLO: lo_d = rs;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (cnt_q == 5'd0) begin
                        case (op_q)
                            OP_MULT:  {hi_d, lo_d} = prod_s;
                            OP_MULTU: {hi_d, lo_d} = prod_u;
                            OP_DIV: begin
                                if (b_q != 32'd0) begin
                                    hi_d = rem_s;
                                    lo_d = quo_s;
                                end
                            end
                            OP_DIVU: begin
                                if (b_q != 32'd0) begin
                                    hi_d = rem_u;
                                    lo_d = quo_u;
                                end
                            end
                            default: ;
                        endcase
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= OP_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Handshake: start is taken only when stall is low; while busy, a presented start or
    // hilo_rd raises stall and the requester must hold and re-present the same request.
    assign stall       = busy_q & (hilo_rd | start);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
